// File: rtl/pixel_streamer_pkg.sv
// Shared types and constants for the pixel streamer: FSM encoding and
// output FIFO sizing.
package pixel_streamer_pkg;

   localparam int FIFO_DEPTH = 4;
   localparam int FIFO_CNT_W = 3;
   localparam int FIFO_PTR_W = 2;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   // Width of a counter that runs 0..n-1, never narrower than one bit.
   function automatic int cntWidth(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/pixel_streamer_if.sv
// Bundle of the frame trigger, image buffer read port and pixel stream.
// The streamer takes the master view; the surrounding system takes slave.
interface pixel_streamer_if #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 10
);

   logic              i_valid;
   logic              o_ren;
   logic [ADDR_W-1:0] o_raddr;
   logic [DATA_W-1:0] i_rdata;
   logic [DATA_W-1:0] o_pixel;
   logic              o_pixel_valid;
   logic              i_pixel_ready;
   logic              o_row_last;
   logic              o_frame_last;
   logic              o_busy;
   logic              o_done;

   modport master (
      input  i_valid,
      input  i_rdata,
      input  i_pixel_ready,
      output o_ren,
      output o_raddr,
      output o_pixel,
      output o_pixel_valid,
      output o_row_last,
      output o_frame_last,
      output o_busy,
      output o_done
   );

   modport slave (
      output i_valid,
      output i_rdata,
      output i_pixel_ready,
      input  o_ren,
      input  o_raddr,
      input  o_pixel,
      input  o_pixel_valid,
      input  o_row_last,
      input  o_frame_last,
      input  o_busy,
      input  o_done
   );

endinterface

// File: rtl/pixel_streamer_pix_fifo4.sv
// Four-entry output FIFO; the head word is always presented on data_o.
// Overflow protection is the caller's job (credit scheme in the streamer).
module pix_fifo4
   import pixel_streamer_pkg::*;
#(
   parameter int DATA_W = 8
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  push_i,
   input  logic [DATA_W-1:0]     data_i,
   input  logic                  pop_i,
   output logic [DATA_W-1:0]     data_o,
   output logic                  full_o,
   output logic                  empty_o,
   output logic [FIFO_CNT_W-1:0] count_o
);

   logic [DATA_W-1:0]     mem_q [FIFO_DEPTH];
   logic [FIFO_PTR_W-1:0] wrPtr_q;
   logic [FIFO_PTR_W-1:0] rdPtr_q;
   logic [FIFO_CNT_W-1:0] count_q;
   logic [FIFO_CNT_W-1:0] count_d;
   logic                  doPop;

   assign empty_o = (count_q == '0);
   assign full_o  = (count_q == FIFO_CNT_W'(FIFO_DEPTH));
   assign count_o = count_q;
   assign data_o  = mem_q[rdPtr_q];
   assign doPop   = pop_i & ~empty_o;

   always_comb begin
      count_d = count_q + FIFO_CNT_W'(push_i) - FIFO_CNT_W'(doPop);
   end

   // Storage is cleared on reset so the head word reads as zero.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         wrPtr_q <= '0;
         rdPtr_q <= '0;
         count_q <= '0;
      end else begin
         if (push_i) begin
            mem_q[wrPtr_q] <= data_i;
            wrPtr_q        <= wrPtr_q + FIFO_PTR_W'(1);
         end
         if (doPop) begin
            rdPtr_q <= rdPtr_q + FIFO_PTR_W'(1);
         end
         count_q <= count_d;
      end
   end

endmodule

// File: rtl/pixel_streamer.sv
// Streams one image frame from the image buffer to the CNN input stage,
// started by a rising edge of i_valid, with credit-based read flow control.
module pixel_streamer
   import pixel_streamer_pkg::*;
#(
   parameter int IMG_W  = 28,
   parameter int IMG_H  = 28,
   parameter int DATA_W = 8,
   parameter int ADDR_W = 10
) (
   input  logic             clk,
   input  logic             reset,
   pixel_streamer_if.master bus
);

   localparam int TOTAL = IMG_W * IMG_H;
   localparam int COL_W = cntWidth(IMG_W);
   localparam int ROW_W = cntWidth(IMG_H);
   localparam int ISS_W = ADDR_W + 1;

   state_t            state_q, state_d;
   logic              validPrev_q;
   logic              ren_q, ren_d;
   logic [ADDR_W-1:0] raddr_q, raddr_d;
   logic [ISS_W-1:0]  issued_q, issued_d;
   logic              rdValid_q;
   logic [COL_W-1:0]  col_q, col_d;
   logic [ROW_W-1:0]  row_q, row_d;
   logic              done_q, done_d;

   logic                  fifoPush;
   logic                  fifoFull;
   logic                  fifoEmpty;
   logic [FIFO_CNT_W-1:0] fifoCount;
   logic [DATA_W-1:0]     fifoHead;

   logic       start;
   logic       handshake;
   logic       rowLast;
   logic       frameLast;
   logic [3:0] countNext;
   logic       creditFree;

   assign start     = (state_q == IDLE) & bus.i_valid & ~validPrev_q;
   assign fifoPush  = rdValid_q & ~fifoFull;
   assign handshake = ~fifoEmpty & bus.i_pixel_ready;
   assign rowLast   = ~fifoEmpty & (col_q == COL_W'(IMG_W - 1));
   assign frameLast = rowLast & (row_q == ROW_W'(IMG_H - 1));

   // A new read may go out only if, after this edge, FIFO contents plus
   // the read already on the bus plus the new one still fit in the FIFO.
   assign countNext  = {1'b0, fifoCount} + {3'b0, fifoPush} - {3'b0, handshake};
   assign creditFree = (countNext + {3'b0, ren_q}) < 4'(FIFO_DEPTH);

   pix_fifo4 #(
      .DATA_W (DATA_W)
   ) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .push_i  (fifoPush),
      .data_i  (bus.i_rdata),
      .pop_i   (handshake),
      .data_o  (fifoHead),
      .full_o  (fifoFull),
      .empty_o (fifoEmpty),
      .count_o (fifoCount)
   );

   // The start edge already issues the read of address 0, so the issue
   // counter resumes at 1; this is what gives the two-edge first-pixel latency.
   always_comb begin
      state_d  = state_q;
      ren_d    = 1'b0;
      raddr_d  = raddr_q;
      issued_d = issued_q;
      col_d    = col_q;
      row_d    = row_q;
      done_d   = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               state_d  = RUN;
               ren_d    = 1'b1;
               raddr_d  = '0;
               issued_d = ISS_W'(1);
               col_d    = '0;
               row_d    = '0;
            end
         end
         RUN: begin
            if ((issued_q < ISS_W'(TOTAL)) && creditFree) begin
               ren_d    = 1'b1;
               raddr_d  = issued_q[ADDR_W-1:0];
               issued_d = issued_q + ISS_W'(1);
            end
            if (handshake) begin
               if (col_q == COL_W'(IMG_W - 1)) begin
                  col_d = '0;
                  row_d = row_q + ROW_W'(1);
               end else begin
                  col_d = col_q + COL_W'(1);
               end
               if (frameLast) begin
                  state_d = IDLE;
                  done_d  = 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // validPrev_q resets high so a trigger already asserted through reset
   // is not mistaken for a fresh rising edge.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         validPrev_q <= 1'b1;
         ren_q       <= 1'b0;
         raddr_q     <= '0;
         issued_q    <= '0;
         rdValid_q   <= 1'b0;
         col_q       <= '0;
         row_q       <= '0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         validPrev_q <= bus.i_valid;
         ren_q       <= ren_d;
         raddr_q     <= raddr_d;
         issued_q    <= issued_d;
         rdValid_q   <= ren_q;
         col_q       <= col_d;
         row_q       <= row_d;
         done_q      <= done_d;
      end
   end

   assign bus.o_ren         = ren_q;
   assign bus.o_raddr       = raddr_q;
   assign bus.o_pixel       = fifoHead;
   assign bus.o_pixel_valid = ~fifoEmpty;
   assign bus.o_row_last    = rowLast;
   assign bus.o_frame_last  = frameLast;
   assign bus.o_busy        = (state_q == RUN);
   assign bus.o_done        = done_q;

endmodule

// File: doc/pixel_streamer.md
PIXEL_STREAMER -- requirements
Module: pixel_streamer

Interface
REQ-001 Parameter IMG_W, default 28: image width in pixels.
REQ-002 Parameter IMG_H, default 28: image height in pixels.
REQ-003 Parameter DATA_W, default 8: pixel width in bits.
REQ-004 Parameter ADDR_W, default 10: image buffer address width; SHALL satisfy 2^ADDR_W >= IMG_W*IMG_H.
REQ-005 clk  in  1  single clock; all logic on the rising edge.
REQ-006 reset  in  1  asynchronous, active-high reset.
REQ-007 i_valid  in  1  frame-ready window from the valid-window stretcher; only its rising edge is used.
REQ-008 o_ren  out  1  image buffer read enable.
REQ-009 o_raddr  out  ADDR_W  image buffer read address, linear row-major order.
REQ-010 i_rdata  in  DATA_W  image buffer read data, valid exactly one cycle after o_ren.
REQ-011 o_pixel  out  DATA_W  pixel to the CNN input stage.
REQ-012 o_pixel_valid  out  1  o_pixel is valid.
REQ-013 i_pixel_ready  in  1  CNN stage accepts the pixel.
REQ-014 o_row_last  out  1  current pixel is the last one of its row.
REQ-015 o_frame_last  out  1  current pixel is the last one of the frame.
REQ-016 o_busy  out  1  a frame is in progress.
REQ-017 o_done  out  1  one-cycle pulse at the end of the frame.

Function
REQ-018 The FSM SHALL have states IDLE and RUN; o_busy SHALL be 1 exactly while in RUN.
REQ-019 Start: at an edge where the FSM is in IDLE, i_valid=1 and the registered previous i_valid=0, the FSM SHALL enter RUN, the address counter SHALL clear to 0, and all pixel counters SHALL clear.
REQ-020 A rising edge of i_valid while in RUN SHALL be ignored; a level-high i_valid after a frame ends SHALL NOT restart the frame.
REQ-021 Reads SHALL be issued at addresses 0 to IMG_W*IMG_H-1 in order, one per asserted o_ren, and each address exactly once; o_ren SHALL be registered.
REQ-022 Credit rule: (pixels stored in the output FIFO) + (reads in flight) SHALL never exceed 4; o_ren SHALL be asserted whenever a credit is free and addresses remain.
REQ-023 Data arriving on i_rdata SHALL be written into a 4-entry output FIFO on the next edge; the FIFO head SHALL drive o_pixel, and o_pixel_valid SHALL equal FIFO non-empty.
REQ-024 Latency: the first o_pixel_valid SHALL be visible after the 2nd edge following the start edge.
REQ-025 Throughput: with i_pixel_ready held at 1, the block SHALL deliver one pixel per cycle without gaps.
REQ-026 A handshake SHALL be o_pixel_valid & i_pixel_ready. o_pixel and o_pixel_valid SHALL stay stable while valid=1 and ready=0.
REQ-027 A FIFO push and pop in the same cycle SHALL leave the occupancy unchanged; push into a full FIFO SHALL be impossible by REQ-022.
REQ-028 Column and row counters SHALL advance on each handshake; column SHALL wrap from IMG_W-1 to 0 and increment the row.
REQ-029 o_row_last SHALL be 1 when o_pixel_valid=1 and column=IMG_W-1; o_frame_last SHALL be 1 when additionally row=IMG_H-1.
REQ-030 On the handshake of the frame_last pixel, the FSM SHALL return to IDLE at that edge and o_done SHALL be 1 for exactly the following cycle.

Reset
REQ-031 On reset the FSM SHALL be IDLE, the FIFO empty, counters and credits 0, and every output 0, including o_raddr and o_pixel.
REQ-032 Reset mid-frame SHALL abort the frame without an o_done pulse; in-flight read data SHALL be discarded.
REQ-033 The previous-i_valid register SHALL reset to 1, so an i_valid held high through reset does not start a frame.

Structure
REQ-034 A shared package SHALL hold the state encoding (IDLE, RUN) and the FIFO depth constant (4).
REQ-035 The output FIFO SHALL be a sub-module, pix_fifo4: DATA_W wide, 4 entries, push/pop/full/empty/count.

Verification
REQ-036 Basic frame: i_valid 0->1 held for 1000 cycles, ready=1 -> 784 pixels equal to buffer[0..783] in order, no gaps, first valid 2 edges after start, o_done once.
REQ-037 Backpressure: ready toggles 1/0 at random -> the same 784 values, none lost or duplicated, o_pixel stable while stalled, at most 4 outstanding.
REQ-038 Flags: ready=1 -> o_row_last on pixels 27, 55, ..., 783; o_frame_last only on pixel 783.
REQ-039 Re-trigger: a second i_valid rise at pixel 100 -> ignored, exactly 784 pixels; a rise after o_done -> a new frame starting at address 0.
REQ-040 Reset mid-frame at pixel 300 -> all outputs 0 next cycle, no o_done; a later i_valid rise -> a full frame from address 0.
REQ-041 Reset with i_valid held high, then reset released -> no frame starts until i_valid falls and rises again.
